instr_decoder: RTL

- Decode/issue stage directly upstream of the execute stage.
- Accepts 16-bit instruction halfwords from fetch and assembles 32-bit (format VI) instructions.
- Reads operands from the architectural register array and drives the execute stage's operand/control inputs with one registered issue per instruction.
- Provides a one-cycle interlock against the execute stage's one-cycle register write-back latency.

---
 rtl/instr_decoder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/instr_decoder.sv
// Decode/issue stage: assembles 16/32-bit instructions, reads operands,
// and issues one registered operation per instruction to execute.
module instr_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] hw_i,
  input  logic        hw_valid_i,
  output logic        hw_ready_o,
  input  logic [31:0] GR_i [32],
  output logic [4:0]  destination_o,
  output logic [31:0] reg1_o,
  output logic [31:0] reg2_o,
  output logic [31:0] reg3_o,
  output logic        increment_bit_o,
  output logic [4:0]  circuit_sel_o,
  output logic        issue_valid_o,
  output logic        illegal_o
);

  localparam logic [1:0] FETCH1 = 2'd0;
  localparam logic [1:0] FETCH2 = 2'd1;
  localparam logic [1:0] STALL  = 2'd2;

  localparam logic [4:0] SEL_NOP = 5'b11111;

  logic [1:0]  state;
  logic [15:0] hw1_q;
  logic [15:0] imm_q;

  logic [15:0] hw1;
  logic [15:0] imm;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic [5:0]  op;
  logic [31:0] va;
  logic [31:0] vb;

  logic        legal;
  logic [4:0]  sel;
  logic [4:0]  dest;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        use_a;
  logic        use_b;

  logic is32;
  logic accept;
  logic fin;
  logic nop;
  logic haz;
  logic do_issue;
  logic do_illegal;

  assign reg3_o          = 32'd0;
  assign increment_bit_o = 1'b0;
  assign hw_ready_o      = (state != STALL);

  // Halfword 1 is live from hw_i only while in FETCH1.
  assign hw1 = (state == FETCH1) ? hw_i : hw1_q;
  assign imm = (state == FETCH2) ? hw_i : imm_q;
  assign ra  = hw1[15:11];
  assign op  = hw1[10:5];
  assign rb  = hw1[4:0];
  assign va  = (ra == 5'd0) ? 32'd0 : GR_i[ra];
  assign vb  = (rb == 5'd0) ? 32'd0 : GR_i[rb];

  always_comb begin
    legal = 1'b1;
    sel   = SEL_NOP;
    dest  = ra;
    op1   = 32'd0;
    op2   = 32'd0;
    use_a = 1'b0;
    use_b = 1'b0;
    case (op)
      6'b001110: begin
        sel = 5'b00001; op1 = vb; op2 = va;
        use_a = 1'b1; use_b = 1'b1;
      end
      6'b010010: begin
        sel = 5'b00001; op1 = {{27{rb[4]}}, rb};
        op2 = va; use_a = 1'b1;
      end
      6'b110000: begin
        sel = 5'b00001; op1 = {{16{imm[15]}}, imm};
        op2 = vb; use_b = 1'b1;
      end
      6'b001101, 6'b001111: begin
        sel = 5'b00000; op1 = (~vb) + 32'd1; op2 = va;
        use_a = 1'b1; use_b = 1'b1;
        if (op[1]) dest = 5'd0;
      end
      6'b001010: begin
        sel = 5'b00010; op1 = vb; op2 = va;
        use_a = 1'b1; use_b = 1'b1;
      end
      6'b001000: begin
        sel = 5'b00011; op1 = vb; op2 = va;
        use_a = 1'b1; use_b = 1'b1;
      end
      6'b110110: begin
        sel = 5'b00010; op1 = {16'd0, imm};
        op2 = vb; use_b = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  assign is32   = (op[5:4] == 2'b11);
  assign accept = hw_valid_i && hw_ready_o;
  assign nop    = (hw1 == 16'h0000);
  assign fin    = ((state == FETCH1) && accept && !is32)
               || ((state == FETCH2) && accept)
               || (state == STALL);

  // Previous edge's issue is still on the outputs; its result commits now.
  assign haz = (state != STALL) && issue_valid_o
            && (destination_o != 5'd0)
            && ((use_a && (ra == destination_o))
             || (use_b && (rb == destination_o)));

  assign do_issue   = fin && legal && !haz;
  assign do_illegal = fin && !legal && !nop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= FETCH1;
      hw1_q         <= 16'd0;
      imm_q         <= 16'd0;
      issue_valid_o <= 1'b0;
      illegal_o     <= 1'b0;
      circuit_sel_o <= SEL_NOP;
      destination_o <= 5'd0;
      reg1_o        <= 32'd0;
      reg2_o        <= 32'd0;
    end else begin
      issue_valid_o <= do_issue;
      illegal_o     <= do_illegal;
      if (do_issue) begin
        circuit_sel_o <= sel;
        destination_o <= dest;
        reg1_o        <= op1;
        reg2_o        <= op2;
      end else begin
        circuit_sel_o <= SEL_NOP;
        destination_o <= 5'd0;
      end
      if (accept && (state == FETCH1)) hw1_q <= hw_i;
      if (accept && (state == FETCH2)) imm_q <= hw_i;
      case (state)
        FETCH1: begin
          if (accept && is32) state <= FETCH2;
          else if (fin && legal && haz) state <= STALL;
        end
        FETCH2: begin
          if (accept) state <= (legal && haz) ? STALL : FETCH1;
        end
        default: state <= FETCH1;
      endcase
    end
  end

endmodule
